// File: rtl/bcd_convert_arbiter.sv
// Shared binary-to-BCD converter: round-robin arbitration between two requesters,
// followed by an 8-cycle double-dabble conversion with a one-cycle acknowledge.
module bcd_convert_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    input  logic [7:0]  bin0_i,
    input  logic [7:0]  bin1_i,
    output logic [1:0]  ack_o,
    output logic [11:0] bcd_out_o,
    output logic        bcd_id_o,
    output logic        bcd_valid_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [19:0] sr_q, sr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        grant_q, grant_d;
    logic [1:0]  ack_q, ack_d;
    logic        valid_q, valid_d;
    logic [11:0] bcd_q, bcd_d;
    logic        id_q, id_d;
    logic        busy_q, busy_d;

    logic        pick;
    logic [19:0] corr;
    logic [19:0] shifted;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Under contention the requester not served last wins.
    assign pick = (req_i == 2'b11) ? ~last_q : req_i[1];

    assign corr    = {add3(sr_q[19:16]), add3(sr_q[15:12]), add3(sr_q[11:8]), sr_q[7:0]};
    assign shifted = {corr[18:0], 1'b0};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        ack_d   = 2'b00;
        valid_d = 1'b0;
        bcd_d   = bcd_q;
        id_d    = id_q;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    grant_d = pick;
                    last_d  = pick;
                    sr_d    = {12'h000, (pick ? bin1_i : bin0_i)};
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                sr_d  = shifted;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    bcd_d   = shifted[19:8];
                    id_d    = grant_q;
                    ack_d   = grant_q ? 2'b10 : 2'b01;
                    valid_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= 20'h00000;
            cnt_q   <= 3'd0;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            ack_q   <= 2'b00;
            valid_q <= 1'b0;
            bcd_q   <= 12'h000;
            id_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            bcd_q   <= bcd_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
        end
    end

    assign ack_o       = ack_q;
    assign bcd_out_o   = bcd_q;
    assign bcd_id_o    = id_q;
    assign bcd_valid_o = valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed bench for bcd_convert_arbiter: vector table plus hand-written
// contention, fairness, input-stability, mid-conversion reset and a full sweep.
module tb_bcd_convert_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  bin0;
    logic [7:0]  bin1;
    logic [1:0]  ack;
    logic [11:0] bcd_out;
    logic        bcd_id;
    logic        bcd_valid;
    logic        busy;

    int tests  = 0;
    int failed = 0;
    int busy_seen;

    bcd_convert_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .bin0_i     (bin0),
        .bin1_i     (bin1),
        .ack_o      (ack),
        .bcd_out_o  (bcd_out),
        .bcd_id_o   (bcd_id),
        .bcd_valid_o(bcd_valid),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [1:0]  ack;
        logic [11:0] bcd;
        logic        id;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns posedges elapsed until ack is seen (-1 on timeout).
    task automatic wait_ack(output int lat);
        lat = 0;
        busy_seen = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy) busy_seen++;
        end while (ack == 2'b00 && lat < 40);
        if (ack == 2'b00) begin
            tests++;
            failed++;
            $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack", lat);
            lat = -1;
        end
    endtask

    task automatic post_done(input string name);
        @(posedge clk);
        @(negedge clk);
        check({name, "_ack_clear"}, 32'(ack), 32'(2'b00));
        check({name, "_valid_clear"}, 32'(bcd_valid), 32'(1'b0));
        check({name, "_busy_clear"}, 32'(busy), 32'(1'b0));
    endtask

    initial begin
        int lat;
        vecs[0] = '{req: 2'b01, b0: 8'd255, b1: 8'd3,   ack: 2'b01, bcd: 12'h255, id: 1'b0};
        vecs[1] = '{req: 2'b10, b0: 8'd77,  b1: 8'd100, ack: 2'b10, bcd: 12'h100, id: 1'b1};
        vecs[2] = '{req: 2'b01, b0: 8'd0,   b1: 8'd50,  ack: 2'b01, bcd: 12'h000, id: 1'b0};
        vecs[3] = '{req: 2'b01, b0: 8'd9,   b1: 8'd0,   ack: 2'b01, bcd: 12'h009, id: 1'b0};
        vecs[4] = '{req: 2'b10, b0: 8'd1,   b1: 8'd10,  ack: 2'b10, bcd: 12'h010, id: 1'b1};
        vecs[5] = '{req: 2'b01, b0: 8'd199, b1: 8'd2,   ack: 2'b01, bcd: 12'h199, id: 1'b0};
        vecs[6] = '{req: 2'b10, b0: 8'd5,   b1: 8'd250, ack: 2'b10, bcd: 12'h250, id: 1'b1};

        rst  = 1'b1;
        req  = 2'b00;
        bin0 = 8'd0;
        bin1 = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ack", 32'(ack), 32'(2'b00));
        check("reset_bcd", 32'(bcd_out), 32'(12'h000));
        check("reset_busy", 32'(busy), 32'(1'b0));
        check("reset_valid", 32'(bcd_valid), 32'(1'b0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            req  = vecs[i].req;
            bin0 = vecs[i].b0;
            bin1 = vecs[i].b1;
            wait_ack(lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_seen), 32'd9);
            check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
            check($sformatf("vec%0d_valid", i), 32'(bcd_valid), 32'(1'b1));
            check($sformatf("vec%0d_bcd", i), 32'(bcd_out), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_id", i), 32'(bcd_id), 32'(vecs[i].id));
            req = 2'b00;
            post_done($sformatf("vec%0d", i));
        end

        // Contention straight out of reset: requester 0 first, then 1 ten cycles later.
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        req  = 2'b11;
        bin0 = 8'd42;
        bin1 = 8'd100;
        wait_ack(lat);
        check("cont_first_ack", 32'(ack), 32'(2'b01));
        check("cont_first_bcd", 32'(bcd_out), 32'(12'h042));
        check("cont_first_id", 32'(bcd_id), 32'(1'b0));
        req = 2'b10;
        wait_ack(lat);
        check("cont_spacing", 32'(lat), 32'd10);
        check("cont_second_ack", 32'(ack), 32'(2'b10));
        check("cont_second_bcd", 32'(bcd_out), 32'(12'h100));
        check("cont_second_id", 32'(bcd_id), 32'(1'b1));
        req = 2'b00;
        post_done("cont");

        // Fairness with both requests held.
        req  = 2'b11;
        bin0 = 8'd17;
        bin1 = 8'd83;
        for (int k = 0; k < 4; k++) begin
            wait_ack(lat);
            check($sformatf("fair%0d_id", k), 32'(bcd_id), 32'(k % 2));
            check($sformatf("fair%0d_bcd", k), 32'(bcd_out), 32'((k % 2) ? 12'h083 : 12'h017));
        end
        req = 2'b00;
        post_done("fair");

        // bin1 changes after grant must not disturb the in-flight result.
        req  = 2'b10;
        bin1 = 8'd99;
        repeat (4) @(posedge clk);
        #1 bin1 = 8'd7;
        @(negedge clk);
        wait_ack(lat);
        check("stable_bcd", 32'(bcd_out), 32'(12'h099));
        check("stable_id", 32'(bcd_id), 32'(1'b1));
        req = 2'b00;
        post_done("stable");

        // Asynchronous reset mid-conversion.
        req  = 2'b01;
        bin0 = 8'd200;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_bcd", 32'(bcd_out), 32'(12'h000));
        check("midrst_id", 32'(bcd_id), 32'(1'b0));
        check("midrst_ack", 32'(ack), 32'(2'b00));
        check("midrst_busy", 32'(busy), 32'(1'b0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midrst_hold%0d_ack", k), 32'(ack), 32'(2'b00));
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_regrant_busy", 32'(busy), 32'(1'b1));
        wait_ack(lat);
        check("midrst_regrant_latency", 32'(lat), 32'd8);
        check("midrst_regrant_bcd", 32'(bcd_out), 32'(12'h200));
        req = 2'b00;
        post_done("midrst");

        // Full sweep through requester 0.
        for (int v = 0; v < 256; v++) begin
            req  = 2'b01;
            bin0 = 8'(v);
            wait_ack(lat);
            check($sformatf("sweep%0d_bcd", v), 32'(bcd_out), 32'(ref_bcd(v)));
            req = 2'b00;
            @(posedge clk);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
